// File: rtl/usb_pll_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_pll_pkg
// Description : Shared state encoding and PLL dynamic-control defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package usb_pll_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_st_rst    = 3'd0;
    localparam state_t c_st_wait   = 3'd1;
    localparam state_t c_st_stable = 3'd2;
    localparam state_t c_st_run    = 3'd3;
    localparam state_t c_st_fail   = 3'd4;

    localparam logic [3:0] c_psda_default   = 4'b0000;
    localparam logic [3:0] c_dutyda_default = 4'b1000;

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Generic two-flop synchronizer with synchronous reset to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            o_q    <= '0;
        end else begin
            r_meta <= i_d;
            o_q    <= r_meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/usb_pll_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : usb_pll_ctrl
// Description : USB rPLL supervisor: reset sequencing, lock watchdog with
//               retries, USB reset release and PSDA/DUTYDA config port.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_pll_ctrl
    import usb_pll_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4800,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRY     = 3,
    parameter int CNT_W         = 16
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       lock,
    input  logic       relock_req,
    input  logic       cfg_valid,
    input  logic [3:0] cfg_psda,
    input  logic [3:0] cfg_dutyda,
    output logic       cfg_ready,
    output logic       pll_reset,
    output logic [3:0] psda,
    output logic [3:0] dutyda,
    output logic       usb_rst,
    output logic       ready,
    output logic       fail,
    output logic [1:0] retry_cnt
);

    localparam logic [CNT_W-1:0] c_rst_load    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_wait_load   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_stable_load = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [1:0]       c_max_retry   = 2'(MAX_RETRY);

    logic             w_lock_s;
    state_t           r_state;
    state_t           w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [1:0]       w_retry_nx;
    logic             w_cnt_zero;

    sync2 #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk (clkin),
        .rst (reset),
        .i_d (lock),
        .o_q (w_lock_s)
    );

    assign w_cnt_zero = (r_cnt == '0);

    // One down-counter serves all timed states; each transition reloads it
    // with the duration of the state being entered.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_retry_nx = retry_cnt;
        case (r_state)
            c_st_rst: begin
                if (relock_req) begin
                    w_cnt_nx = c_rst_load;
                end else if (w_cnt_zero) begin
                    w_state_nx = c_st_wait;
                    w_cnt_nx   = c_wait_load;
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            c_st_wait: begin
                if (relock_req) begin
                    w_state_nx = c_st_rst;
                    w_cnt_nx   = c_rst_load;
                end else if (w_lock_s) begin
                    w_state_nx = c_st_stable;
                    w_cnt_nx   = c_stable_load;
                end else if (w_cnt_zero) begin
                    if (retry_cnt < c_max_retry) begin
                        w_retry_nx = retry_cnt + 2'd1;
                        w_state_nx = c_st_rst;
                        w_cnt_nx   = c_rst_load;
                    end else begin
                        w_state_nx = c_st_fail;
                    end
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            c_st_stable: begin
                if (relock_req) begin
                    w_state_nx = c_st_rst;
                    w_cnt_nx   = c_rst_load;
                end else if (!w_lock_s) begin
                    // A glitch restarts the lock wait but is not a retry.
                    w_state_nx = c_st_wait;
                    w_cnt_nx   = c_wait_load;
                end else if (w_cnt_zero) begin
                    w_state_nx = c_st_run;
                    w_retry_nx = 2'd0;
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            c_st_run: begin
                if (relock_req || !w_lock_s) begin
                    w_state_nx = c_st_rst;
                    w_cnt_nx   = c_rst_load;
                end
            end
            c_st_fail: begin
                if (relock_req) begin
                    w_state_nx = c_st_rst;
                    w_cnt_nx   = c_rst_load;
                    w_retry_nx = 2'd0;
                end
            end
            default: begin
                w_state_nx = c_st_rst;
                w_cnt_nx   = c_rst_load;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet
    // change on the same edge as the state itself.
    always_ff @(posedge clkin) begin
        if (reset) begin
            r_state   <= c_st_rst;
            r_cnt     <= c_rst_load;
            retry_cnt <= 2'd0;
            pll_reset <= 1'b1;
            usb_rst   <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
            cfg_ready <= 1'b0;
            psda      <= c_psda_default;
            dutyda    <= c_dutyda_default;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            retry_cnt <= w_retry_nx;
            pll_reset <= (w_state_nx == c_st_rst);
            usb_rst   <= (w_state_nx != c_st_run);
            ready     <= (w_state_nx == c_st_run);
            fail      <= (w_state_nx == c_st_fail);
            cfg_ready <= (w_state_nx == c_st_run);
            if (cfg_valid && cfg_ready) begin
                psda   <= cfg_psda;
                dutyda <= cfg_dutyda;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_pll_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_pll_ctrl
// Description : Self-checking bench for usb_pll_ctrl with a timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_pll_ctrl;

    localparam int R  = 4;
    localparam int T  = 20;
    localparam int S  = 8;
    localparam int MR = 2;

    logic       clkin = 1'b0;
    logic       reset;
    logic       lock;
    logic       relock_req;
    logic       cfg_valid;
    logic [3:0] cfg_psda;
    logic [3:0] cfg_dutyda;
    logic       cfg_ready;
    logic       pll_reset;
    logic [3:0] psda;
    logic [3:0] dutyda;
    logic       usb_rst;
    logic       ready;
    logic       fail;
    logic [1:0] retry_cnt;

    always #5 clkin = ~clkin;

    usb_pll_ctrl #(
        .RST_CYCLES    (R),
        .LOCK_TIMEOUT  (T),
        .STABLE_CYCLES (S),
        .MAX_RETRY     (MR),
        .CNT_W         (16)
    ) dut (
        .clkin      (clkin),
        .reset      (reset),
        .lock       (lock),
        .relock_req (relock_req),
        .cfg_valid  (cfg_valid),
        .cfg_psda   (cfg_psda),
        .cfg_dutyda (cfg_dutyda),
        .cfg_ready  (cfg_ready),
        .pll_reset  (pll_reset),
        .psda       (psda),
        .dutyda     (dutyda),
        .usb_rst    (usb_rst),
        .ready      (ready),
        .fail       (fail),
        .retry_cnt  (retry_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: phases with absolute-time deadlines, lock seen two
    // edges late through a sample history.
    typedef enum int {P_RST, P_WAIT, P_STAB, P_RUN, P_FAIL} phase_t;
    phase_t     m_phase    = P_RST;
    int         m_cyc      = 0;
    int         m_deadline = 0;
    int         m_retries  = 0;
    logic [3:0] m_psda     = 4'h0;
    logic [3:0] m_duty     = 4'h8;
    bit         m_cfg_rdy  = 1'b0;
    bit         m_hist[$];

    function automatic int dur(input phase_t p);
        case (p)
            P_RST:   return R;
            P_WAIT:  return T;
            P_STAB:  return S;
            default: return 0;
        endcase
    endfunction

    task automatic enter(input phase_t p);
        m_phase    = p;
        m_deadline = m_cyc + dur(p);
    endtask

    task automatic model_edge();
        bit ls;
        m_cyc++;
        if (reset) begin
            m_retries = 0;
            m_psda    = 4'h0;
            m_duty    = 4'h8;
            m_hist.delete();
            m_hist.push_back(1'b0);
            m_hist.push_back(1'b0);
            enter(P_RST);
        end else begin
            ls = m_hist[0];
            if (cfg_valid && m_cfg_rdy) begin
                m_psda = cfg_psda;
                m_duty = cfg_dutyda;
            end
            case (m_phase)
                P_RST: begin
                    if (relock_req) enter(P_RST);
                    else if (m_cyc == m_deadline) enter(P_WAIT);
                end
                P_WAIT: begin
                    if (relock_req) enter(P_RST);
                    else if (ls) enter(P_STAB);
                    else if (m_cyc == m_deadline) begin
                        if (m_retries < MR) begin
                            m_retries++;
                            enter(P_RST);
                        end else begin
                            enter(P_FAIL);
                        end
                    end
                end
                P_STAB: begin
                    if (relock_req) enter(P_RST);
                    else if (!ls) enter(P_WAIT);
                    else if (m_cyc == m_deadline) begin
                        m_retries = 0;
                        enter(P_RUN);
                    end
                end
                P_RUN: begin
                    if (relock_req || !ls) enter(P_RST);
                end
                default: begin
                    if (relock_req) begin
                        m_retries = 0;
                        enter(P_RST);
                    end
                end
            endcase
            void'(m_hist.pop_front());
            m_hist.push_back(lock);
        end
        m_cfg_rdy = (m_phase == P_RUN);
    endtask

    function automatic logic [31:0] model_vec();
        return {17'd0, m_phase == P_RST, m_phase != P_RUN, m_phase == P_RUN,
                m_phase == P_FAIL, m_cfg_rdy, 2'(m_retries), m_psda, m_duty};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {17'd0, pll_reset, usb_rst, ready, fail, cfg_ready, retry_cnt, psda, dutyda};
    endfunction

    task automatic step();
        @(posedge clkin);
        model_edge();
        #1;
        check("model_outputs", dut_vec(), model_vec());
    endtask

    typedef struct {
        logic       valid;
        logic [3:0] p;
        logic [3:0] d;
        logic [3:0] exp_p;
        logic [3:0] exp_d;
    } cfg_vec_t;

    cfg_vec_t vecs[6];
    int       k;
    int       seg_left;
    int       rseq[$];
    logic [1:0] last_retry;

    initial begin
        vecs[0] = '{1'b1, 4'h3, 4'hA, 4'h3, 4'hA};
        vecs[1] = '{1'b0, 4'hF, 4'hF, 4'h3, 4'hA};
        vecs[2] = '{1'b1, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[3] = '{1'b1, 4'hF, 4'h1, 4'hF, 4'h1};
        vecs[4] = '{1'b0, 4'h7, 4'h7, 4'hF, 4'h1};
        vecs[5] = '{1'b1, 4'h9, 4'hC, 4'h9, 4'hC};

        reset = 1'b1; lock = 1'b0; relock_req = 1'b0;
        cfg_valid = 1'b0; cfg_psda = 4'h0; cfg_dutyda = 4'h0;
        step(); step();
        check("rst_pll_reset", 32'(pll_reset), 32'd1);
        check("rst_usb_rst",   32'(usb_rst),   32'd1);
        check("rst_flags",     {29'd0, ready, fail, cfg_ready}, 32'd0);
        check("rst_retry",     32'(retry_cnt), 32'd0);
        check("rst_cfg",       {24'd0, psda, dutyda}, 32'h08);

        // Normal bring-up
        reset = 1'b0;
        k = 0;
        while (pll_reset && k < 100) begin k++; step(); end
        check("t1_pll_reset_width", 32'(k), 32'(R));
        repeat (10 - R) step();
        lock = 1'b1;
        k = 0;
        while (usb_rst && k < 100) begin step(); k++; end
        check("t1_lock_to_usb_rst", 32'(k), 32'(S + 3));
        check("t1_ready", 32'(ready), 32'd1);
        check("t1_retry", 32'(retry_cnt), 32'd0);

        // Glitch during STABLE
        lock = 1'b0; relock_req = 1'b1; step(); relock_req = 1'b0;
        k = 0;
        while (pll_reset && k < 50) begin step(); k++; end
        lock = 1'b1; repeat (5) step();
        lock = 1'b0; step();
        lock = 1'b1;
        k = 0;
        while (usb_rst && k < 100) begin step(); k++; end
        check("t2_rerise_to_run", 32'(k), 32'(S + 3));
        check("t2_retry", 32'(retry_cnt), 32'd0);

        // Timeout and retry
        lock = 1'b0; relock_req = 1'b1; step(); relock_req = 1'b0;
        last_retry = retry_cnt;
        k = 0;
        while (!fail && k < 500) begin
            step(); k++;
            if (retry_cnt != last_retry) rseq.push_back(int'(retry_cnt));
            last_retry = retry_cnt;
        end
        check("t3_cycles_to_fail", 32'(k), 32'((MR + 1) * (R + T)));
        check("t3_retry_seq", {16'(rseq.size()), 8'(rseq.size() > 0 ? rseq[0] : 0),
                               8'(rseq.size() > 1 ? rseq[1] : 0)}, {16'd2, 8'd1, 8'd2});
        check("t3_fail_state", {28'd0, fail, usb_rst, retry_cnt}, {28'd0, 1'b1, 1'b1, 2'd2});
        repeat (5) step();
        check("t3_fail_sticky", 32'(fail), 32'd1);
        lock = 1'b1; relock_req = 1'b1; step(); relock_req = 1'b0;
        check("t3_relock", {30'd0, pll_reset, fail}, {30'd0, 1'b1, 1'b0});
        check("t3_retry_cleared", 32'(retry_cnt), 32'd0);
        k = 0;
        while (!ready && k < 100) begin step(); k++; end
        check("t3_run", 32'(ready), 32'd1);

        // Lock loss in RUN
        lock = 1'b0;
        step(); check("t4_run_1", 32'(usb_rst), 32'd0);
        step(); check("t4_run_2", 32'(usb_rst), 32'd0);
        step(); check("t4_lost", {30'd0, usb_rst, pll_reset}, {30'd0, 1'b1, 1'b1});

        // Config handshake held across WAIT, transfer on first RUN cycle
        k = 0;
        while (pll_reset && k < 50) begin step(); k++; end
        cfg_valid = 1'b1; cfg_psda = 4'h5; cfg_dutyda = 4'h6;
        repeat (3) step();
        check("t5_wait_hold", {23'd0, cfg_ready, psda, dutyda}, {23'd0, 1'b0, 4'h0, 4'h8});
        lock = 1'b1;
        k = 0;
        while (!cfg_ready && k < 100) begin step(); k++; end
        check("t5_first_run", {23'd0, cfg_ready, psda, dutyda}, {23'd0, 1'b1, 4'h0, 4'h8});
        step();
        check("t5_transfer", {24'd0, psda, dutyda}, 32'h56);
        cfg_valid = 1'b0;
        lock = 1'b0; repeat (5) step();
        lock = 1'b1;
        k = 0;
        while (!ready && k < 100) begin step(); k++; end
        check("t5_relocked", 32'(ready), 32'd1);
        check("t5_retained", {24'd0, psda, dutyda}, 32'h56);

        // Table of handshakes in RUN
        for (int i = 0; i < 6; i++) begin
            cfg_valid = vecs[i].valid; cfg_psda = vecs[i].p; cfg_dutyda = vecs[i].d;
            step();
            check($sformatf("tbl_%0d", i), {23'd0, cfg_ready, psda, dutyda},
                  {23'd0, 1'b1, vecs[i].exp_p, vecs[i].exp_d});
        end
        cfg_valid = 1'b0;

        // Reset during STABLE
        relock_req = 1'b1; step(); relock_req = 1'b0;
        k = 0;
        while (pll_reset && k < 50) begin step(); k++; end
        step(); step();
        reset = 1'b1; step();
        check("t6_reset", dut_vec(), {17'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'h8});
        reset = 1'b0;

        // Random stimulus against the model
        seg_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (seg_left == 0) begin
                lock = ~lock;
                seg_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(40, 110))
                                                       : int'($urandom_range(1, 30));
            end
            seg_left--;
            relock_req = ($urandom_range(0, 79) == 0);
            reset      = ($urandom_range(0, 599) == 0);
            cfg_valid  = 1'($urandom_range(0, 1));
            cfg_psda   = 4'($urandom);
            cfg_dutyda = 4'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
